// File: rtl/popcount_pkg.sv
// Shared width helpers and the result-FIFO entry type for the popcount scheduler.
package popcount_pkg;

  // Entry fields are sized for the largest supported configuration (NUM_REQ <= 8).
  localparam int unsigned MAX_ID_W    = 3;
  localparam int unsigned MAX_COUNT_W = 16;

  function automatic int unsigned count_w(input int unsigned data_width);
    return $clog2(data_width + 1);
  endfunction

  function automatic int unsigned id_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  typedef struct packed {
    logic [MAX_ID_W-1:0]    id;
    logic [MAX_COUNT_W-1:0] count;
  } res_entry_t;

endpackage

// File: rtl/popcount_rr_arb.sv
// Round-robin arbiter: one-hot grant, priority starting after the last accepted grant.
module popcount_rr_arb
  import popcount_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int unsigned PTR_W = id_w(NUM_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_o   = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = PTR_W'((ptr_q + off) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        gnt_o[idx]   = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/popcount_sched.sv
// Shares one fixed-latency popcount engine among NUM_REQ requesters with a credit-protected result FIFO.
// Define POPCOUNT_SCHED_STATS_EN to add stat_issued/stat_stall counters and the stat_clr input.
module popcount_sched
  import popcount_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ENG_LAT    = 2,
  parameter int unsigned RES_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             eng_enable,
  output logic [DATA_WIDTH-1:0]            eng_data,
  input  logic [DATA_WIDTH-1:0]            eng_result,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [id_w(NUM_REQ)-1:0]         rsp_id,
  output logic [count_w(DATA_WIDTH)-1:0]   rsp_count,
  output logic                             busy
`ifdef POPCOUNT_SCHED_STATS_EN
  ,
  input  logic                             stat_clr,
  output logic [31:0]                      stat_issued,
  output logic [31:0]                      stat_stall
`endif
);

  localparam int unsigned COUNT_W = count_w(DATA_WIDTH);
  localparam int unsigned ID_W    = id_w(NUM_REQ);
  localparam int unsigned AW      = $clog2(RES_DEPTH);
  localparam int unsigned OW      = $clog2(RES_DEPTH + 1);

  logic                  run_q;
  logic [OW-1:0]         outst_q, outst_d;
  logic [OW-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  res_entry_t            fifo_mem_q [RES_DEPTH];
  res_entry_t            head, wr_entry;
  logic                  push, pop, issue, credit_ok;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_id;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  eng_enable_q;
  logic [DATA_WIDTH-1:0] eng_data_q;
  logic [ENG_LAT:0]      tag_v_q;
  logic [ID_W-1:0]       tag_id_q [ENG_LAT+1];
  logic                  unused_bits;

  // outst_q counts every op from issue until its FIFO entry is popped, so
  // RES_DEPTH - outst_q is the credit pool; a same-cycle pop returns one credit.
  assign rsp_valid = (fifo_cnt_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = tag_v_q[ENG_LAT];
  assign credit_ok = run_q && ((outst_q != OW'(RES_DEPTH)) || pop);
  assign issue     = |gnt;
  assign req_ready = gnt;
  assign busy      = (outst_q != '0);

  popcount_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid & {NUM_REQ{credit_ok}}),
    .advance_i (issue),
    .gnt_o     (gnt)
  );

  always_comb begin
    gnt_data = '0;
    gnt_id   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_data = gnt_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_id   = ID_W'(i);
      end
    end
  end

  always_comb begin
    outst_d    = outst_q + OW'(issue) - OW'(pop);
    fifo_cnt_d = fifo_cnt_q + OW'(push) - OW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      eng_enable_q <= 1'b0;
      eng_data_q   <= '0;
      outst_q      <= '0;
      fifo_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_v_q      <= '0;
      for (int unsigned i = 0; i <= ENG_LAT; i++) tag_id_q[i] <= '0;
    end else begin
      run_q        <= 1'b1;
      eng_enable_q <= issue;
      if (issue) eng_data_q <= gnt_data;
      outst_q      <= outst_d;
      fifo_cnt_q   <= fifo_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      // Stage 0 is aligned with eng_enable; stage ENG_LAT with the engine result.
      tag_v_q      <= {tag_v_q[ENG_LAT-1:0], issue};
      tag_id_q[0]  <= gnt_id;
      for (int unsigned i = 1; i <= ENG_LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
    end
  end

  assign wr_entry.id    = MAX_ID_W'(tag_id_q[ENG_LAT]);
  assign wr_entry.count = MAX_COUNT_W'(eng_result[COUNT_W-1:0]);

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head       = fifo_mem_q[rd_ptr_q];
  assign rsp_id     = rsp_valid ? head.id[ID_W-1:0]       : '0;
  assign rsp_count  = rsp_valid ? head.count[COUNT_W-1:0] : '0;
  assign eng_enable = eng_enable_q;
  assign eng_data   = eng_data_q;
  assign unused_bits = ^{eng_result, head};

`ifdef POPCOUNT_SCHED_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q;
  logic        stall;

  assign stall = run_q && (|req_valid) && !credit_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else if (stat_clr) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (issue && (stat_issued_q != '1)) stat_issued_q <= stat_issued_q + 32'd1;
      if (stall && (stat_stall_q  != '1)) stat_stall_q  <= stat_stall_q  + 32'd1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_popcount_sched.sv
// Directed bench for popcount_sched with a behavioural fixed-latency engine and a result scoreboard.
module tb_popcount_sched;

  localparam int unsigned DW = 512;
  localparam int unsigned NR = 4;
  localparam int unsigned EL = 2;
  localparam int unsigned RD = 4;

  typedef struct {
    logic [31:0] id;
    logic [31:0] cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              eng_enable;
  logic [DW-1:0]     eng_data;
  logic [DW-1:0]     eng_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [9:0]        rsp_count;
  logic              busy;
`ifdef POPCOUNT_SCHED_STATS_EN
  logic              stat_clr;
  logic [31:0]       stat_issued;
  logic [31:0]       stat_stall;
`endif

  int unsigned       n_checks = 0;
  int unsigned       n_fail   = 0;
  int unsigned       n_acc    = 0;
  exp_t              exp_q [$];
  int unsigned       exp_cnt [NR];
  logic [DW-1:0]     op [NR];
  logic [DW-1:0]     eng_pipe [EL];

  popcount_sched #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .ENG_LAT    (EL),
    .RES_DEPTH  (RD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .eng_enable (eng_enable),
    .eng_data   (eng_data),
    .eng_result (eng_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_count  (rsp_count),
    .busy       (busy)
`ifdef POPCOUNT_SCHED_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Engine stand-in: result valid EL cycles after the cycle eng_enable is seen.
  always_ff @(posedge clk) begin
    eng_pipe[0] <= eng_enable ? DW'($countones(eng_data)) : '0;
    for (int i = 1; i < int'(EL); i++) eng_pipe[i] <= eng_pipe[i-1];
  end
  assign eng_result = eng_pipe[EL-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic observe();
    exp_t e;
    for (int i = 0; i < int'(NR); i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id  = 32'(i);
        e.cnt = 32'(exp_cnt[i]);
        exp_q.push_back(e);
        n_acc++;
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rsp_id", 32'(rsp_id), e.id);
        chk("sb_rsp_count", 32'(rsp_count), e.cnt);
      end
    end
  endtask

  task automatic tick();
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && busy; i++) begin
      #1;
      tick();
    end
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       seen;
    logic [3:0] skip_exp [3];

    op[0] = 512'h0F;
    op[1] = '0;
    op[2] = '1;
    op[3] = 512'hA5A5;
    op[3][511] = 1'b1;
    exp_cnt[0] = 4;
    exp_cnt[1] = 0;
    exp_cnt[2] = 512;
    exp_cnt[3] = 9;
    for (int i = 0; i < int'(NR); i++) req_data[i*DW +: DW] = op[i];
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
`ifdef POPCOUNT_SCHED_STATS_EN
    stat_clr  = 1'b0;
`endif

    // Reset values
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_eng_enable", 32'(eng_enable), 32'd0);
    chk("rst_eng_data", 32'(|eng_data), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_count", 32'(rsp_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    do_reset();

    // Single request from requester 2, all-ones operand
    req_valid = 4'b0100;
    #1; chk("single_gnt", 32'(req_ready), 32'h4); tick();
    req_valid = '0;
    #1;
    chk("single_eng_en", 32'(eng_enable), 32'd1);
    chk("single_eng_data", 32'(&eng_data), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    tick();
    #1; chk("single_eng_en_drop", 32'(eng_enable), 32'd0); tick();
    #1; chk("single_rsp_early", 32'(rsp_valid), 32'd0); tick();
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_id", 32'(rsp_id), 32'd2);
    chk("single_rsp_count", 32'(rsp_count), 32'd512);
    tick();
    #1;
    chk("single_busy_after", 32'(busy), 32'd0);
    chk("single_rsp_after", 32'(rsp_valid), 32'd0);

    // Fairness: all requesters valid, 8 back-to-back issues
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fair_gnt", 32'(req_ready), 32'(1 << (k % 4)));
      tick();
    end
    req_valid = '0;
    drain("fair");

    // Backpressure: credits run out after RES_DEPTH accepts, head held stable
    do_reset();
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    n_acc     = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k >= 4) begin
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_rsp_id", 32'(rsp_id), 32'd0);
        chk("bp_rsp_count", 32'(rsp_count), 32'd4);
      end
      tick();
    end
    chk("bp_accepts", n_acc, 32'd4);
`ifdef POPCOUNT_SCHED_STATS_EN
    chk("stat_issued_bp", stat_issued, 32'd4);
    chk("stat_stall_bp", stat_stall, 32'd8);
`endif
    rsp_ready = 1'b1;
    n_acc     = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      tick();
    end
    chk("bp_resume_accepts", n_acc, 32'd8);
    req_valid = '0;
    drain("bp");
`ifdef POPCOUNT_SCHED_STATS_EN
    chk("stat_issued_total", stat_issued, 32'd12);
    stat_clr = 1'b1;
    #1; tick();
    stat_clr = 1'b0;
    chk("stat_issued_clr", stat_issued, 32'd0);
    chk("stat_stall_clr", stat_stall, 32'd0);
`endif

    // Reset with two operations in flight
    do_reset();
    req_valid = 4'b1100;
    #1; chk("mid_gnt0", 32'(req_ready), 32'h4); tick();
    #1; chk("mid_gnt1", 32'(req_ready), 32'h8); tick();
    #1; chk("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_req_ready", 32'(req_ready), 32'd0);
    chk("mid_eng_enable", 32'(eng_enable), 32'd0);
    chk("mid_eng_data", 32'(|eng_data), 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rsp_id", 32'(rsp_id), 32'd0);
    chk("mid_rsp_count", 32'(rsp_count), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen = seen | rsp_valid;
    end
    chk("mid_no_rsp", 32'(seen), 32'd0);

    // Non-valid requesters are skipped; pointer advances past each grant
    skip_exp[0] = 4'b0010;
    skip_exp[1] = 4'b1000;
    skip_exp[2] = 4'b0010;
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("skip_gnt", 32'(req_ready), 32'(skip_exp[k]));
      tick();
    end
    req_valid = '0;
    drain("skip");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/popcount_sched.md
Name: popcount_sched

Overview:
- Schedules and shares one pipelined 512-bit popcount engine among NUM_REQ requesters.
- Per cycle:
  - round-robin grant of at most one request;
  - issue to the engine;
  - track in-flight operations through a fixed-latency tag pipe;
  - buffer tagged results in a credit-protected FIFO toward a backpressured consumer.
- Sits between the request crossbar and the popcount datapath.

Parameters:
- DATA_WIDTH, 512, operand width issued to the engine.
- NUM_REQ, 4, number of requesters (2..8).
- ENG_LAT, 2, fixed engine latency in cycles from eng_enable to a valid eng_result (>=1).
- RES_DEPTH, 4, result FIFO depth (power of 2, >=2).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, NUM_REQ, per-requester request valid.
- req_data, in, NUM_REQ*DATA_WIDTH, operands; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready, out, NUM_REQ, one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- eng_enable, out, 1, engine issue strobe.
- eng_data, out, DATA_WIDTH, operand to engine.
- eng_result, in, DATA_WIDTH, engine output; only low COUNT_W bits are used.
- rsp_valid, out, 1, result available.
- rsp_ready, in, 1, consumer accepts the result.
- rsp_id, out, ID_W, originating requester index.
- rsp_count, out, COUNT_W, popcount value.
- busy, out, 1, high while any operation is in flight or the FIFO is non-empty.

Behaviour:
- Widths: COUNT_W = clog2(DATA_WIDTH+1) (10 at default); ID_W = clog2(NUM_REQ), minimum 1.
- Reset (async assert, sync deassert assumed upstream) clears:
  - req_ready=0, eng_enable=0, eng_data=0;
  - rsp_valid=0, rsp_id=0, rsp_count=0, busy=0;
  - RR pointer=0, tag pipe empty, FIFO empty, credits=RES_DEPTH.
- Credit: credits = RES_DEPTH - fifo_count - inflight. Issue is allowed only when credits>0, so the FIFO never overflows and the engine is never stalled.
- Arbitration:
  - combinational RR over req_valid, gated by credits>0;
  - priority starts at the index after the last grant;
  - pointer updates only on an accepted request;
  - req_ready is one-hot or zero and never asserts to a non-valid requester.
- Issue: on accept in cycle T, eng_enable=1 and eng_data=the selected operand, both registered and visible in cycle T+1. The tag pipe {valid,id} enters at T+1.
- Capture: the tag pipe is ENG_LAT stages deep. When the stage-ENG_LAT tag is valid, the low COUNT_W bits of eng_result and the id are pushed into the FIFO that cycle.
- Latency: request accept to rsp_valid = ENG_LAT+2 cycles when the FIFO is empty.
- FIFO:
  - show-ahead; rsp_* are driven from the head entry;
  - pop on rsp_valid & rsp_ready;
  - rsp_valid/rsp_id/rsp_count are stable while rsp_valid=1 and rsp_ready=0.
- Simultaneous push and pop when full is legal; count is unchanged.
- Simultaneous issue and pop: credit accounting uses the pre-cycle count plus the pop this cycle, so one credit is returned in the same cycle.
- Throughput: one issue per cycle sustained when rsp_ready=1 and RES_DEPTH >= ENG_LAT+2.
- Reset mid-operation: all in-flight tags and FIFO contents are discarded; no rsp_valid follows reset.
- rsp_count wraps never (COUNT_W covers DATA_WIDTH); the value is passed through unchanged.

Optional Feature:
- Macro: POPCOUNT_SCHED_STATS_EN.
- With the macro, the block adds:
  - output stat_issued[31:0], counting accepted requests;
  - output stat_stall[31:0], counting cycles with any req_valid but no grant due to zero credits.
- Both stats counters saturate at 0xFFFFFFFF, reset to 0, and are cleared synchronously by input stat_clr (clear wins over increment).
- Without the macro, these ports and counters do not exist.

Decomposition:
- Package popcount_pkg holds:
  - COUNT_W function (clog2(DATA_WIDTH+1));
  - ID_W derivation;
  - result entry struct {id, count}.
- One sub-module, popcount_rr_arb: NUM_REQ request vector plus advance strobe in, one-hot grant out, with an internal pointer.
- The FIFO and tag pipe stay inline.

Test Plan:
- Single request: requester 2 with all-ones operand, rsp_ready=1. Expect eng_enable 1 cycle after accept; rsp_valid, rsp_id=2, rsp_count=512 at ENG_LAT+2 cycles; busy=0 the next cycle.
- Fairness: all 4 requesters continuously valid, 8 issues. Expect grant order 0,1,2,3,0,1,2,3 and operand 0x0F in slot 0 yielding count 4.
- Backpressure: rsp_ready=0 with continuous requests. Expect exactly RES_DEPTH (4) accepts, then req_ready=0 and rsp_* held stable. Raising rsp_ready resumes one issue per returned credit with no loss.
- Simultaneous edge cases:
  - operand 0, expect count 0;
  - FIFO full with push and pop in the same cycle, expect count unchanged and ordering preserved.
- Reset mid-flight: assert rst_n=0 with 2 in flight. Expect all outputs at reset values immediately and no rsp_valid after release.
- Stats (POPCOUNT_SCHED_STATS_EN): the backpressure scenario gives stat_issued=4 and stat_stall=cycles stalled; stat_clr zeroes both counters.
